// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end for the shared registered ALU: accepts one
// command, sequences ALU EN/OE so result and all flags settle, then returns them.
module alu_arbiter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  input  logic [3:0]       REQ0_OPCODE,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [3:0]       REQ1_OPCODE,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  output logic             REQ1_READY,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_CF,
  output logic             RSP_OF,
  output logic             RSP_SF,
  output logic             RSP_ZF,
  output logic             RSP_ERR,
  output logic [3:0]       ALU_OPCODE,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic             ALU_EN,
  output logic             ALU_OE,
  input  logic [WIDTH-1:0] ALU_RESULT,
  input  logic             ALU_CF,
  input  logic             ALU_OF,
  input  logic             ALU_SF,
  input  logic             ALU_ZF,
  output logic [2:0]       DBG_STATE
);

  // Handshakes: a transfer happens on the rising edge where VALID and READY are
  // both high; VALID is held by the sender until then, READY may drop any time.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC1 = 3'd1,
    EXEC2 = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic             last_gnt;
  logic             gnt_any;
  logic             gnt_idx;
  logic             accept;
  logic             op_ok;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Round-robin only matters on a tie; otherwise the lone requester wins.
  always_comb begin
    gnt_any = REQ0_VALID | REQ1_VALID;
    gnt_idx = (REQ0_VALID & REQ1_VALID) ? ~last_gnt : REQ1_VALID;
    accept  = (state == IDLE) & gnt_any & ~RST;
    sel_op  = gnt_idx ? REQ1_OPCODE : REQ0_OPCODE;
    sel_a   = gnt_idx ? REQ1_A : REQ0_A;
    sel_b   = gnt_idx ? REQ1_B : REQ0_B;
    op_ok   = (sel_op >= 4'b0010) && (sel_op <= 4'b0111);
  end

  assign REQ0_READY = accept & ~gnt_idx;
  assign REQ1_READY = accept & gnt_idx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ALU_EN    = 1'b0;
    ALU_OE    = 1'b0;
    RSP_VALID = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = op_ok ? EXEC1 : RESP;
      EXEC1: begin
        ALU_EN    = 1'b1;
        ALU_OE    = 1'b1;
        state_nxt = EXEC2;
      end
      // Second enable edge lets SF/ZF follow the freshly registered result.
      EXEC2: begin
        ALU_EN    = 1'b1;
        ALU_OE    = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: begin
        ALU_OE    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_gnt <= 1'b1;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      RSP_ID   <= 1'b0;
      RSP_DATA <= '0;
      RSP_CF   <= 1'b0;
      RSP_OF   <= 1'b0;
      RSP_SF   <= 1'b0;
      RSP_ZF   <= 1'b0;
      RSP_ERR  <= 1'b0;
    end else if (accept) begin
      last_gnt <= gnt_idx;
      RSP_ID   <= gnt_idx;
      op_q     <= sel_op;
      a_q      <= sel_a;
      b_q      <= sel_b;
      RSP_DATA <= '0;
      RSP_CF   <= 1'b0;
      RSP_OF   <= 1'b0;
      RSP_SF   <= 1'b0;
      RSP_ZF   <= 1'b0;
      RSP_ERR  <= ~op_ok;
    end else if (state == CAPT) begin
      RSP_DATA <= ALU_RESULT;
      RSP_CF   <= ALU_CF;
      RSP_OF   <= ALU_OF;
      RSP_SF   <= ALU_SF;
      RSP_ZF   <= ALU_ZF;
      RSP_ERR  <= 1'b0;
    end
  end

  assign ALU_OPCODE = op_q;
  assign ALU_A      = a_q;
  assign ALU_B      = b_q;
  assign DBG_STATE  = state;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl with a behavioural registered ALU whose
// SF/ZF lag the result by one enable edge, as the real ALU does.
module tb_alu_arbiter_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [3:0]   REQ0_OPCODE = '0, REQ1_OPCODE = '0;
  logic [W-1:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
  logic         REQ0_READY, REQ1_READY;
  logic         RSP_VALID, RSP_ID, RSP_CF, RSP_OF, RSP_SF, RSP_ZF, RSP_ERR;
  logic         RSP_READY = 1'b1;
  logic [W-1:0] RSP_DATA;
  logic [3:0]   ALU_OPCODE;
  logic [W-1:0] ALU_A, ALU_B, ALU_RESULT;
  logic         ALU_EN, ALU_OE, ALU_CF, ALU_OF, ALU_SF, ALU_ZF;
  logic [2:0]   DBG_STATE;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  alu_arbiter_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_OPCODE(REQ0_OPCODE), .REQ0_A(REQ0_A),
    .REQ0_B(REQ0_B), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_OPCODE(REQ1_OPCODE), .REQ1_A(REQ1_A),
    .REQ1_B(REQ1_B), .REQ1_READY(REQ1_READY),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DATA(RSP_DATA), .RSP_CF(RSP_CF), .RSP_OF(RSP_OF), .RSP_SF(RSP_SF),
    .RSP_ZF(RSP_ZF), .RSP_ERR(RSP_ERR),
    .ALU_OPCODE(ALU_OPCODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_RESULT(ALU_RESULT),
    .ALU_CF(ALU_CF), .ALU_OF(ALU_OF), .ALU_SF(ALU_SF), .ALU_ZF(ALU_ZF),
    .DBG_STATE(DBG_STATE)
  );

  // Behavioural ALU: result/CF/OF register on EN, SF/ZF derive from the old result.
  logic [W-1:0] alu_q = '0;
  logic         alu_cf = 1'b0, alu_of = 1'b0, alu_sf = 1'b0, alu_zf = 1'b0;

  always @(posedge CLK) begin
    if (ALU_EN) begin
      logic [W:0] t;
      logic       ovf;
      t   = '0;
      ovf = 1'b0;
      case (ALU_OPCODE)
        4'b0010: begin
          t   = {1'b0, ALU_A} + {1'b0, ALU_B};
          ovf = (ALU_A[W-1] == ALU_B[W-1]) && (t[W-1] != ALU_A[W-1]);
        end
        4'b0011: begin
          t   = {1'b0, ALU_A} - {1'b0, ALU_B};
          ovf = (ALU_A[W-1] != ALU_B[W-1]) && (t[W-1] != ALU_A[W-1]);
        end
        4'b0100: t = {1'b0, ALU_A & ALU_B};
        4'b0101: t = {1'b0, ALU_A | ALU_B};
        4'b0110: t = {1'b0, ALU_A ^ ALU_B};
        4'b0111: t = {1'b0, ~ALU_A};
        default: t = '0;
      endcase
      alu_q  <= t[W-1:0];
      alu_cf <= t[W];
      alu_of <= ovf;
      alu_sf <= alu_q[W-1];
      alu_zf <= (alu_q == '0);
    end
  end

  assign ALU_RESULT = ALU_OE ? alu_q : '0;
  assign ALU_CF = alu_cf;
  assign ALU_OF = alu_of;
  assign ALU_SF = alu_sf;
  assign ALU_ZF = alu_zf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {RSP_VALID, RSP_ID, RSP_DATA, RSP_CF, RSP_OF, RSP_SF, RSP_ZF, RSP_ERR,
            ALU_OPCODE, ALU_A, ALU_EN, ALU_OE, REQ0_READY, REQ1_READY} | {24'd0, ALU_B};
  endfunction

  task automatic set_req(input int idx, input logic v, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (idx == 0) begin
      REQ0_VALID = v; REQ0_OPCODE = op; REQ0_A = a; REQ0_B = b;
    end else begin
      REQ1_VALID = v; REQ1_OPCODE = op; REQ1_A = a; REQ1_B = b;
    end
  endtask

  // Raise VALID, wait (bounded) for READY, take the accept edge, drop VALID.
  task automatic issue(input int idx, input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic rdy;
    @(negedge CLK);
    set_req(idx, 1'b1, op, a, b);
    n = 0;
    #1;
    rdy = (idx == 0) ? REQ0_READY : REQ1_READY;
    while (!rdy && n < 20) begin
      @(negedge CLK);
      #1;
      rdy = (idx == 0) ? REQ0_READY : REQ1_READY;
      n++;
    end
    check("ready", {31'd0, rdy}, 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    set_req(idx, 1'b0, 4'b0000, '0, '0);
  endtask

  // exp_f = {err, cf, of, sf, zf}; hold = cycles of RSP_READY=0 once valid.
  task automatic run_cmd(input int idx, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_d,
                         input logic [4:0] exp_f, input int exp_lat, input int hold);
    int lat, en_cnt, oe_cnt;
    logic [31:0] snap;
    issue(idx, op, a, b);
    lat = 1; en_cnt = 0; oe_cnt = 0;
    while (!RSP_VALID && lat < 20) begin
      en_cnt += int'(ALU_EN);
      oe_cnt += int'(ALU_OE);
      @(negedge CLK);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("en_cycles", en_cnt, (exp_lat == 4) ? 2 : 0);
    check("oe_cycles", oe_cnt, (exp_lat == 4) ? 3 : 0);
    check("oe_in_resp", {30'd0, ALU_EN, ALU_OE}, 32'd0);
    check("rsp_id", {31'd0, RSP_ID}, idx);
    check("rsp_data", {24'd0, RSP_DATA}, {24'd0, exp_d});
    check("rsp_flags", {27'd0, RSP_ERR, RSP_CF, RSP_OF, RSP_SF, RSP_ZF}, {27'd0, exp_f});
    if (hold > 0) begin
      snap = {RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, RSP_CF, RSP_OF, RSP_SF, RSP_ZF};
      set_req(1 - idx, 1'b1, 4'b0010, 8'h01, 8'h01);
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK);
        check("bp_stable", {RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, RSP_CF, RSP_OF, RSP_SF, RSP_ZF}, snap);
        check("bp_no_ready", {30'd0, REQ0_READY, REQ1_READY}, 32'd0);
      end
      set_req(1 - idx, 1'b0, 4'b0000, '0, '0);
      RSP_READY = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
    check("rsp_drop", {31'd0, RSP_VALID}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  logic [W-1:0] exp_q[$];
  logic         gnt_q[$];

  initial begin
    #12;
    check("reset_outs", all_outs(), 32'd0);
    check("reset_state", {29'd0, DBG_STATE}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    run_cmd(0, 4'b0010, 8'h7F, 8'h01, 8'h80, 5'b00110, 4, 0);
    run_cmd(1, 4'b0011, 8'h05, 8'h05, 8'h00, 5'b00001, 4, 0);
    run_cmd(0, 4'b0011, 8'h03, 8'h05, 8'hFE, 5'b01010, 4, 0);
    run_cmd(0, 4'b1111, 8'h12, 8'h34, 8'h00, 5'b10000, 1, 0);
    run_cmd(1, 4'b0111, 8'h0F, 8'h00, 8'hF0, 5'b00010, 4, 0);

    // Both requesters held: grants must alternate starting at 0 after reset.
    do_reset();
    gnt_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
    @(negedge CLK);
    set_req(0, 1'b1, 4'b0110, 8'hF0, 8'h0F);
    set_req(1, 1'b1, 4'b0110, 8'hF0, 8'h0F);
    for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
      @(negedge CLK);
      check("one_ready", {31'd0, REQ0_READY & REQ1_READY}, 32'd0);
      if (RSP_VALID) begin
        check("rr_id", {31'd0, RSP_ID}, {31'd0, gnt_q.pop_front()});
        check("rr_data", {24'd0, RSP_DATA}, {24'd0, exp_q.pop_front()});
        check("rr_flags", {27'd0, RSP_ERR, RSP_CF, RSP_OF, RSP_SF, RSP_ZF}, 32'b00010);
        if (exp_q.size() == 0) begin
          set_req(0, 1'b0, 4'b0000, '0, '0);
          set_req(1, 1'b0, 4'b0000, '0, '0);
        end
      end
    end
    check("rr_left", exp_q.size(), 0);
    @(negedge CLK);

    // Backpressure: five cycles of RSP_READY=0 in RESP.
    @(negedge CLK);
    RSP_READY = 1'b0;
    run_cmd(1, 4'b0100, 8'hF0, 8'h3C, 8'h30, 5'b00000, 4, 5);
    RSP_READY = 1'b0;
    run_cmd(0, 4'b0101, 8'h80, 8'h01, 8'h81, 5'b00010, 4, 5);
    RSP_READY = 1'b1;

    // Async reset during EXEC2 aborts silently.
    issue(0, 4'b0010, 8'h10, 8'h20);
    @(posedge CLK);
    #1;
    check("at_exec2", {29'd0, DBG_STATE}, 32'd2);
    #1;
    RST = 1'b1;
    #1;
    check("mid_reset_outs", all_outs(), 32'd0);
    check("mid_reset_state", {29'd0, DBG_STATE}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("no_rsp_after_rst", {31'd0, RSP_VALID}, 32'd0);
    end
    run_cmd(1, 4'b0010, 8'hFF, 8'h01, 8'h00, 5'b01001, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
